// File: rtl/bcd_serial_convert_ctrl_pkg.sv
// Shared types and constants for the serial BCD-to-binary converter.
package bcd_conv_pkg;

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    localparam logic [3:0] DIGIT_MAX     = 4'd9;
    localparam int         TENS_SHIFT_HI = 3;
    localparam int         TENS_SHIFT_LO = 1;

endpackage

// File: rtl/bcd_serial_convert_ctrl_binary_adder.sv
// One-bit combinational full adder; the controller owns the carry register.
module binary_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bcd_serial_convert_ctrl.sv
// Two-digit BCD to binary converter: tens*10 + units via two bit-serial addition
// passes through one shared full adder, wrapped in a start/busy/done handshake.
module bcd_serial_convert_ctrl
    import bcd_conv_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       tens,
    input  logic [3:0]       units,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ACC_W-1:0] result
);

    localparam int                CNT_W    = $clog2(ACC_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACC_W - 1);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, op_a, op_b, result_q;
    logic [ACC_W-1:0]   acc_shift;
    logic [3:0]         units_q;
    logic [CNT_W-1:0]   cnt;
    logic               carry, err_q;
    logic               sum_bit, cout_bit;
    logic               digits_bad, pass_last;

    binary_adder u_adder (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (sum_bit),
        .cout (cout_bit)
    );

    assign digits_bad = (tens > DIGIT_MAX) || (units > DIGIT_MAX);
    assign pass_last  = (cnt == CNT_LAST);
    // Sum bits arrive LSB first and enter at the MSB, so after ACC_W shifts the word is aligned.
    assign acc_shift  = {sum_bit, acc[ACC_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = digits_bad ? DONE : PASS1;
            PASS1:   if (pass_last) state_nxt = PASS2;
            PASS2:   if (pass_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            units_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        units_q <= units;
                        acc     <= '0;
                        carry   <= 1'b0;
                        cnt     <= '0;
                        if (digits_bad) begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                        end else begin
                            op_a <= ACC_W'(tens) << TENS_SHIFT_HI;
                            op_b <= ACC_W'(tens) << TENS_SHIFT_LO;
                        end
                    end
                end
                PASS1, PASS2: begin
                    acc   <= acc_shift;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= cout_bit;
                    cnt   <= cnt + 1'b1;
                    if (pass_last) begin
                        if (state == PASS1) begin
                            op_a  <= acc_shift;
                            op_b  <= ACC_W'(units_q);
                            carry <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            result_q <= acc_shift;
                            err_q    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Operands never exceed 99, so the last bit of either pass cannot carry out.
    always_ff @(posedge clk) begin
        if (!rst && (state == PASS1 || state == PASS2) && pass_last)
            assert (cout_bit == 1'b0);
    end
`endif

    assign busy   = (state == PASS1) || (state == PASS2);
    assign done   = (state == DONE);
    assign err    = err_q;
    assign result = result_q;

endmodule
